// File: rtl/sa_main_mem_if.sv
// sa_main_mem_if -- request/response bundle between sa_cache_controller
// (master) and sa_main_mem (slave).
//
//   cache_to_mem : addr[19:0] block address, data[127:0] write-back block,
//                  rw (1 = write-back, 0 = block fetch), valid (request strobe)
//   mem_to_cache : data[127:0] fetched block, ready (one-cycle completion pulse)
//
// Handshake: a request is taken on a rising edge where valid=1 and the memory
// is idle; the memory then ignores the request fields until it has returned a
// single-cycle ready pulse. data on mem_to_cache is meaningful only while
// ready=1 and is 0 otherwise.
interface sa_main_mem_if;

  typedef struct packed {
    logic [19:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } cache_to_mem_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_to_cache_type;

  cache_to_mem_type cache_to_mem;
  mem_to_cache_type mem_to_cache;

  modport master (output cache_to_mem, input mem_to_cache);
  modport slave  (input cache_to_mem, output mem_to_cache);

endinterface

// File: rtl/sa_main_mem.sv
// sa_main_mem -- fixed-latency block memory model behind sa_cache_controller.
//
// A request taken in IDLE is held for LATENCY cycles (BUSY), then DONE drives
// a registered one-cycle ready pulse. Reads return the stored block during
// DONE; writes commit the latched block at the edge that ends DONE.
//
// Parameters:
//   LATENCY (1..255) : cycles from acceptance to the ready pulse
//   ADDR_W  (<= 20)  : block-address bits indexing the array; upper request
//                      address bits are dropped (aliasing, no error)
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous, active-low reset
//   bus         : sa_main_mem_if.slave (cache_to_mem in, mem_to_cache out)
//   dbg_state   : current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//   stat_reads  : completed reads, 32-bit wrapping   (only with SA_MEM_STATS_EN)
//   stat_writes : completed writes, 32-bit wrapping  (only with SA_MEM_STATS_EN)
//
// Optional feature macro: SA_MEM_STATS_EN (completion counters).
// The array has no reset and starts zeroed; reset only clears control state.
module sa_main_mem #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 20
) (
  input  logic          clk,
  input  logic          rst,
  sa_main_mem_if.slave  bus,
  output logic [1:0]    dbg_state
`ifdef SA_MEM_STATS_EN
  ,
  output logic [31:0]   stat_reads,
  output logic [31:0]   stat_writes
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [127:0]        wdata_q;
  logic                rw_q;
  logic                ready_q;
  logic [127:0]        rdata_q;

  logic [127:0]        mem [0:(1<<ADDR_W)-1];

  logic                accept;
  logic                enter_done;
  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_rw;

  assign accept = (state_q == IDLE) && bus.cache_to_mem.valid;

  // With LATENCY=1 DONE is entered on the acceptance edge itself, so the
  // read lookup must use the incoming request rather than the latched copy.
  assign cur_addr = accept ? bus.cache_to_mem.addr[ADDR_W-1:0] : addr_q;
  assign cur_rw   = accept ? bus.cache_to_mem.rw : rw_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.cache_to_mem.valid) state_d = (LATENCY == 1) ? DONE : BUSY;
      BUSY: if (cnt_q <= 8'd1) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_done = (state_d == DONE) && (state_q != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= bus.cache_to_mem.addr[ADDR_W-1:0];
        wdata_q <= bus.cache_to_mem.data;
        rw_q    <= bus.cache_to_mem.rw;
        cnt_q   <= 8'(LATENCY - 1);
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - 8'd1;
      end
      ready_q <= enter_done;
      rdata_q <= (enter_done && !cur_rw) ? mem[cur_addr] : '0;
    end
  end

  // Write commits at the edge closing DONE; reset forces IDLE asynchronously,
  // so an aborted write never gets here.
  always_ff @(posedge clk) begin
    if (state_q == DONE && rw_q) mem[addr_q] <= wdata_q;
  end

`ifdef SA_MEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_reads  <= 32'd0;
      stat_writes <= 32'd0;
    end else if (state_q == DONE) begin
      if (rw_q) stat_writes <= stat_writes + 32'd1;
      else      stat_reads  <= stat_reads + 32'd1;
    end
  end
`endif

  assign bus.mem_to_cache.ready = ready_q;
  assign bus.mem_to_cache.data  = rdata_q;
  assign dbg_state              = state_q;

endmodule

// File: tb/tb_sa_main_mem.sv
// tb_sa_main_mem -- directed bench for sa_main_mem.
// dut_a: LATENCY=4, ADDR_W=20. dut_b: LATENCY=1, ADDR_W=8 (aliasing).
module tb_sa_main_mem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sa_main_mem_if if_a ();
  sa_main_mem_if if_b ();
  logic [1:0] st_a, st_b;
`ifdef SA_MEM_STATS_EN
  logic [31:0] sr_a, sw_a, sr_b, sw_b;
`endif

  sa_main_mem #(.LATENCY(4), .ADDR_W(20)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .dbg_state(st_a)
`ifdef SA_MEM_STATS_EN
    , .stat_reads(sr_a), .stat_writes(sw_a)
`endif
  );

  sa_main_mem #(.LATENCY(1), .ADDR_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .dbg_state(st_b)
`ifdef SA_MEM_STATS_EN
    , .stat_reads(sr_b), .stat_writes(sw_b)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;
  int exp_rd_a = 0, exp_wr_a = 0, exp_rd_b = 0, exp_wr_b = 0;

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] PAT_P  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] PAT_Q  = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
  localparam logic [127:0] PAT_C  = 128'h5A5A_0000_FFFF_1234_8765_4321_0F0F_F0F0;

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic v, input logic [19:0] a,
                       input logic [127:0] d, input logic rw);
    if (sel == 0) if_a.cache_to_mem = '{addr: a, data: d, rw: rw, valid: v};
    else          if_b.cache_to_mem = '{addr: a, data: d, rw: rw, valid: v};
  endtask

  task automatic sample(input int sel, output logic rdy, output logic [127:0] d);
    if (sel == 0) begin rdy = if_a.mem_to_cache.ready; d = if_a.mem_to_cache.data; end
    else          begin rdy = if_b.mem_to_cache.ready; d = if_b.mem_to_cache.data; end
  endtask

  // One transaction over a fixed 12-edge window. Valid is held for hold edges,
  // then dropped with the request fields scrambled. k counts edges after the
  // acceptance edge (k=0); first_k is where ready is first seen.
  task automatic run_txn(input int sel, input logic [19:0] a, input logic [127:0] d,
                         input logic rw, input int hold, output int first_k,
                         output int pulses, output logic [127:0] rdata, output int nz);
    logic r;
    logic [127:0] dd;
    drive(sel, 1'b1, a, d, rw);
    first_k = -1; pulses = 0; rdata = '0; nz = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == hold - 1) drive(sel, 1'b0, ~a, ~d, ~rw);
      sample(sel, r, dd);
      if (r) begin
        pulses++;
        if (first_k < 0) begin first_k = k; rdata = dd; end
      end else if (dd !== '0) nz++;
    end
    if (sel == 0) begin if (rw) exp_wr_a++; else exp_rd_a++; end
    else          begin if (rw) exp_wr_b++; else exp_rd_b++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    drive(0, 1'b0, 20'h0, '0, 1'b0);
    drive(1, 1'b0, 20'h0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (if_a.mem_to_cache.ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", if_a.mem_to_cache.ready); end
    tests_run++; if (if_a.mem_to_cache.data !== '0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", if_a.mem_to_cache.data); end
    tests_run++; if (st_a !== 2'd0) begin tests_failed++; $display("FAIL reset_state_a: got %0d expected 0", st_a); end
    tests_run++; if (st_b !== 2'd0) begin tests_failed++; $display("FAIL reset_state_b: got %0d expected 0", st_b); end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_write_read();
    int fk, np, nz;
    logic [127:0] rd;
    run_txn(0, 20'h00010, PAT_A5, 1'b1, 1, fk, np, rd, nz);
    tests_run++; if (fk !== 3) begin tests_failed++; $display("FAIL wr_latency: got %0d expected 3", fk); end
    tests_run++; if (np !== 1) begin tests_failed++; $display("FAIL wr_pulses: got %0d expected 1", np); end
    tests_run++; if (rd !== '0) begin tests_failed++; $display("FAIL wr_done_data: got %h expected 0", rd); end
    tests_run++; if (nz !== 0) begin tests_failed++; $display("FAIL wr_idle_data: got %0d nonzero expected 0", nz); end
    run_txn(0, 20'h00010, '0, 1'b0, 1, fk, np, rd, nz);
    tests_run++; if (fk !== 3) begin tests_failed++; $display("FAIL rd_latency: got %0d expected 3", fk); end
    tests_run++; if (rd !== PAT_A5) begin tests_failed++; $display("FAIL rd_data: got %h expected %h", rd, PAT_A5); end
    tests_run++; if (nz !== 0) begin tests_failed++; $display("FAIL rd_idle_data: got %0d nonzero expected 0", nz); end
  endtask

  task automatic test_unwritten();
    int fk, np, nz;
    logic [127:0] rd;
    run_txn(0, 20'h3FFFF, PAT_Q, 1'b0, 1, fk, np, rd, nz);
    tests_run++; if (fk !== 3) begin tests_failed++; $display("FAIL unwr_latency: got %0d expected 3", fk); end
    tests_run++; if (rd !== '0) begin tests_failed++; $display("FAIL unwr_data: got %h expected 0", rd); end
  endtask

  task automatic test_valid_drop();
    int fk, np, nz;
    logic [127:0] rd;
    run_txn(0, 20'h00020, 128'h1, 1'b1, 2, fk, np, rd, nz);
    tests_run++; if (fk !== 3) begin tests_failed++; $display("FAIL drop_latency: got %0d expected 3", fk); end
    tests_run++; if (np !== 1) begin tests_failed++; $display("FAIL drop_pulses: got %0d expected 1", np); end
    run_txn(0, 20'h00020, '0, 1'b0, 1, fk, np, rd, nz);
    tests_run++; if (rd !== 128'h1) begin tests_failed++; $display("FAIL drop_readback: got %h expected 1", rd); end
  endtask

  task automatic test_back_to_back();
    int fk, np, nz, pulses, k1, k2;
    logic [127:0] rd, dd, rd2;
    logic r;
    run_txn(0, 20'h00456, PAT_P, 1'b1, 1, fk, np, rd, nz);
    drive(0, 1'b1, 20'h00123, PAT_Q, 1'b1);
    pulses = 0; k1 = -1; k2 = -1; rd2 = '0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (k == 0) drive(0, 1'b1, 20'h00456, PAT_C, 1'b0);
      sample(0, r, dd);
      if (r) begin
        pulses++;
        if (k1 < 0) k1 = k;
        else if (k2 < 0) begin k2 = k; rd2 = dd; end
      end
      if (k == 8) drive(0, 1'b0, 20'h0, '0, 1'b0);
    end
    exp_wr_a++; exp_rd_a++;
    tests_run++; if (k1 !== 3) begin tests_failed++; $display("FAIL b2b_first: got %0d expected 3", k1); end
    tests_run++; if (k2 !== 8) begin tests_failed++; $display("FAIL b2b_second: got %0d expected 8", k2); end
    tests_run++; if (pulses !== 2) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 2", pulses); end
    tests_run++; if (rd2 !== PAT_P) begin tests_failed++; $display("FAIL b2b_rdata: got %h expected %h", rd2, PAT_P); end
    run_txn(0, 20'h00123, '0, 1'b0, 1, fk, np, rd, nz);
    tests_run++; if (rd !== PAT_Q) begin tests_failed++; $display("FAIL b2b_wb_readback: got %h expected %h", rd, PAT_Q); end
  endtask

  task automatic test_reset_abort();
    int fk, np, nz, pulses;
    logic [127:0] rd, dd;
    logic r;
    drive(0, 1'b1, 20'h00030, 128'hFF, 1'b1);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 0) drive(0, 1'b0, 20'h0, '0, 1'b0);
      if (k == 2) begin
        rst = 1'b0;
        #1;
        tests_run++; if (st_a !== 2'd0) begin tests_failed++; $display("FAIL abort_state: got %0d expected 0", st_a); end
        #1 rst = 1'b1;
      end
      sample(0, r, dd);
      if (r) pulses++;
    end
    exp_rd_a = 0; exp_wr_a = 0; exp_rd_b = 0; exp_wr_b = 0;
    tests_run++; if (pulses !== 0) begin tests_failed++; $display("FAIL abort_ready: got %0d pulses expected 0", pulses); end
    run_txn(0, 20'h00030, '0, 1'b0, 1, fk, np, rd, nz);
    tests_run++; if (fk !== 3) begin tests_failed++; $display("FAIL abort_next_latency: got %0d expected 3", fk); end
    tests_run++; if (rd !== '0) begin tests_failed++; $display("FAIL abort_readback: got %h expected 0", rd); end
  endtask

  task automatic test_latency1_alias();
    int fk, np, nz;
    logic [127:0] rd;
    run_txn(1, 20'h00105, PAT_C, 1'b1, 1, fk, np, rd, nz);
    tests_run++; if (fk !== 0) begin tests_failed++; $display("FAIL l1_wr_latency: got %0d expected 0", fk); end
    tests_run++; if (np !== 1) begin tests_failed++; $display("FAIL l1_wr_pulses: got %0d expected 1", np); end
    run_txn(1, 20'h00005, '0, 1'b0, 1, fk, np, rd, nz);
    tests_run++; if (fk !== 0) begin tests_failed++; $display("FAIL l1_rd_latency: got %0d expected 0", fk); end
    tests_run++; if (rd !== PAT_C) begin tests_failed++; $display("FAIL l1_alias_data: got %h expected %h", rd, PAT_C); end
    tests_run++; if (nz !== 0) begin tests_failed++; $display("FAIL l1_idle_data: got %0d nonzero expected 0", nz); end
    run_txn(1, 20'h000FF, '0, 1'b0, 1, fk, np, rd, nz);
    tests_run++; if (rd !== '0) begin tests_failed++; $display("FAIL l1_unwritten: got %h expected 0", rd); end
    run_txn(1, 20'h00007, PAT_P, 1'b1, 1, fk, np, rd, nz);
    run_txn(1, 20'hFFF07, '0, 1'b0, 1, fk, np, rd, nz);
    tests_run++; if (rd !== PAT_P) begin tests_failed++; $display("FAIL l1_alias_hi: got %h expected %h", rd, PAT_P); end
  endtask

`ifdef SA_MEM_STATS_EN
  task automatic test_stats();
    tests_run++; if (sr_a !== 32'(exp_rd_a)) begin tests_failed++; $display("FAIL stat_reads_a: got %0d expected %0d", sr_a, exp_rd_a); end
    tests_run++; if (sw_a !== 32'(exp_wr_a)) begin tests_failed++; $display("FAIL stat_writes_a: got %0d expected %0d", sw_a, exp_wr_a); end
    tests_run++; if (sr_b !== 32'd3) begin tests_failed++; $display("FAIL stat_reads_b: got %0d expected 3", sr_b); end
    tests_run++; if (sw_b !== 32'd2) begin tests_failed++; $display("FAIL stat_writes_b: got %0d expected 2", sw_b); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_unwritten();
    test_valid_drop();
    test_reset_abort();
    test_back_to_back();
    test_latency1_alias();
`ifdef SA_MEM_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sa_main_mem.md
SA_MAIN_MEM -- requirements
Module: sa_main_mem

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request acceptance to the ready pulse; legal range 1..255.
REQ-002 Parameter ADDR_W, default 20: block-address bits used to index the backing array (2^ADDR_W blocks of cache_data_type).
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port cache_to_mem, input, cache_to_mem_type (addr 20, data 128, rw 1, valid 1): request from sa_cache_controller; rw=1 write-back, rw=0 block fetch.
REQ-006 Port mem_to_cache, output, mem_to_cache_type (data 128, ready 1): response to sa_cache_controller.
REQ-007 Ports stat_reads and stat_writes, outputs, 32 each: completed-transaction counters; present only under SA_MEM_STATS_EN.

Function
REQ-008 The block SHALL implement FSM states IDLE, BUSY, DONE; the reset state is IDLE.
REQ-009 In IDLE with cache_to_mem.valid=1 at a rising edge, the block SHALL latch addr[ADDR_W-1:0], data and rw, load the latency counter with LATENCY-1, and enter BUSY (LATENCY>1) or DONE (LATENCY=1).
REQ-010 In BUSY, the counter SHALL decrement once per cycle; on reaching 0 the FSM SHALL enter DONE.
REQ-011 In DONE, mem_to_cache.ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; ready is driven from a register only.
REQ-012 A request accepted at edge T SHALL have ready high in the cycle following edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
REQ-013 Write (latched rw=1): the array entry at the latched address SHALL be updated with the latched data at the edge that ends the DONE cycle; mem_to_cache.data SHALL be 0 during that DONE cycle.
REQ-014 Read (latched rw=0): mem_to_cache.data SHALL carry the array entry at the latched address during the DONE cycle, including data written by any earlier completed write.
REQ-015 mem_to_cache.data SHALL be 0 whenever ready=0.
REQ-016 Request inputs SHALL be ignored in BUSY and DONE; deasserting valid, or changing addr, data or rw, mid-transaction SHALL NOT cancel or alter the transaction.
REQ-017 valid still high in the DONE cycle SHALL NOT start a new transaction. The next acceptance is the first IDLE edge after DONE, giving back-to-back write-back then allocate one idle cycle between ready pulses.
REQ-018 An address above 2^ADDR_W-1 SHALL alias by truncation; no error is signalled.
REQ-019 Array contents SHALL be all zero at time 0 and SHALL NOT be affected by reset.

Reset
REQ-020 On rst=0, the block SHALL asynchronously force state=IDLE, counter=0, mem_to_cache.ready=0, mem_to_cache.data=0, and clear stat counters when present.
REQ-021 Reset during BUSY or DONE SHALL abort the transaction; a pending write SHALL NOT reach the array and no ready pulse SHALL follow.
REQ-022 The first acceptance after reset SHALL occur at the first rising edge with rst=1 and valid=1.

Configuration
REQ-023 Macro SA_MEM_STATS_EN defined: stat_reads and stat_writes SHALL exist and each SHALL increment by 1 at the end of every read or write DONE cycle respectively, wrapping from 2^32-1 to 0.
REQ-024 Macro SA_MEM_STATS_EN undefined: those ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-025 LATENCY=4: write addr=0x00010, data=0xA5..A5 (128b), rw=1 accepted at cycle 0 -> ready=1 only in cycle 4, data=0; then read addr=0x00010 -> data=0xA5..A5 with ready.
REQ-026 Read of an unwritten addr=0x3FFFF -> ready after 4 cycles, data=0.
REQ-027 Write-back to 0x00123 followed by allocate read of 0x00456 with valid held high throughout -> two ready pulses at cycles 4 and 9, exactly two transactions, read data correct.
REQ-028 valid dropped in cycle 1 of a write to 0x00020, data=0x1 -> ready still in cycle 4; a later read of 0x00020 returns 0x1.
REQ-029 rst=0 in cycle 2 of a write to 0x00030, data=0xFF -> ready stays 0; a later read of 0x00030 returns 0.
REQ-030 With SA_MEM_STATS_EN and LATENCY=1: 3 reads and 2 writes -> stat_reads=3, stat_writes=2, ready one cycle after each acceptance.
